// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: two-master (instruction bus, data bus), one-slave Wishbone
// arbiter. Round-robin on ties, registered grant, grant held for the whole
// cyc of the owning master, zero-latency request and ack paths once granted.
// Optional stall watchdog is compiled in when WB_ARB_TIMEOUT_EN is defined.
module wb_bus_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_core,
    input  logic                    rst_core,
    // instruction master
    input  logic                    ibus_cyc,
    input  logic                    ibus_stb,
    input  logic                    ibus_we,
    input  logic [DATA_WIDTH/8-1:0] ibus_wstrb,
    input  logic [ADDR_WIDTH-1:0]   ibus_addr,
    input  logic [DATA_WIDTH-1:0]   ibus_data_out,
    output logic [DATA_WIDTH-1:0]   ibus_data_in,
    output logic                    ibus_ack,
    // data master
    input  logic                    dbus_cyc,
    input  logic                    dbus_stb,
    input  logic                    dbus_we,
    input  logic [DATA_WIDTH/8-1:0] dbus_wstrb,
    input  logic [ADDR_WIDTH-1:0]   dbus_addr,
    input  logic [DATA_WIDTH-1:0]   dbus_data_out,
    output logic [DATA_WIDTH-1:0]   dbus_data_in,
    output logic                    dbus_ack,
    // shared slave
    output logic                    mem_cyc,
    output logic                    mem_stb,
    output logic                    mem_we,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_data_out,
    input  logic [DATA_WIDTH-1:0]   mem_data_in,
    input  logic                    mem_ack,
    // status
    output logic [1:0]              grant,
    output logic                    timeout
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    r_last_grant;   // 0 = ibus served last, 1 = dbus
    logic                    w_i_req;
    logic                    w_d_req;
    logic                    w_fire;         // watchdog terminates the transfer this cycle
    logic [DATA_WIDTH-1:0]   w_dead;         // error read data returned on a watchdog hit

    assign w_i_req = ibus_cyc & ibus_stb;
    assign w_d_req = dbus_cyc & dbus_stb;

    // A zero or negative watchdog limit would never be reachable; reject it at elaboration.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("wb_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int          CNT_RAW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int          CNT_W     = (CNT_RAW < 8) ? 8 : ((CNT_RAW > 32) ? 32 : CNT_RAW);
    localparam logic [31:0] DEAD_WORD = 32'hDEAD_BEEF;

    logic [CNT_W-1:0] r_cnt;
    logic             w_cur_cyc;
    logic             w_cur_stb;
    logic             w_stall;
    logic             w_enter;

    // Zero-extend or truncate the 32-bit error word to the bus width.
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_dead
        if (gi < 32) begin : g_word_bit
            assign w_dead[gi] = DEAD_WORD[gi];
        end else begin : g_zero_bit
            assign w_dead[gi] = 1'b0;
        end
    end

    // Select the owning master's cyc/stb before the watchdog force is applied.
    always_comb begin
        w_cur_cyc = 1'b0;
        w_cur_stb = 1'b0;
        case (r_state)
            ST_GRANT_I: begin w_cur_cyc = ibus_cyc; w_cur_stb = ibus_stb; end
            ST_GRANT_D: begin w_cur_cyc = dbus_cyc; w_cur_stb = dbus_stb; end
            default:    begin w_cur_cyc = 1'b0;     w_cur_stb = 1'b0;     end
        endcase
    end

    // The count holds completed stalled cycles, so the hit lands on stalled cycle TIMEOUT_CYCLES.
    assign w_stall = w_cur_cyc & w_cur_stb & ~mem_ack;
    assign w_fire  = w_stall & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) & ~rst_core;
    assign w_enter = (w_state_next != ST_IDLE) && (w_state_next != r_state);

    // Stall counter: restarts on each new grant and on every forwarded ack.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            r_cnt <= '0;
        end else if (w_enter || (mem_ack && w_cur_cyc) || w_fire) begin
            r_cnt <= '0;
        end else if (w_stall) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_fire = 1'b0;
    assign w_dead = '0;
`endif

    // State register and round-robin memory; last_grant moves only when a grant is entered.
    always_ff @(posedge clk_core) begin
        if (rst_core) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_state_next;
            if ((w_state_next != ST_IDLE) && (w_state_next != r_state)) begin
                r_last_grant <= (w_state_next == ST_GRANT_D);
            end
        end
    end

    // Next-state: arbitrate from IDLE, hold while the owner keeps cyc, hand off directly.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_i_req && w_d_req) begin
                    w_state_next = r_last_grant ? ST_GRANT_I : ST_GRANT_D;
                end else if (w_i_req) begin
                    w_state_next = ST_GRANT_I;
                end else if (w_d_req) begin
                    w_state_next = ST_GRANT_D;
                end
            end
            ST_GRANT_I: begin
                if (w_fire) begin
                    w_state_next = ST_IDLE;
                end else if (!ibus_cyc) begin
                    w_state_next = w_d_req ? ST_GRANT_D : ST_IDLE;
                end
            end
            ST_GRANT_D: begin
                if (w_fire) begin
                    w_state_next = ST_IDLE;
                end else if (!dbus_cyc) begin
                    w_state_next = w_i_req ? ST_GRANT_I : ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output routing: the owner sees the slave, everything else is held at zero.
    // Acks are qualified by the owner's cyc and suppressed while reset is asserted.
    always_comb begin
        mem_cyc      = 1'b0;
        mem_stb      = 1'b0;
        mem_we       = 1'b0;
        mem_wstrb    = '0;
        mem_addr     = '0;
        mem_data_out = '0;
        ibus_ack     = 1'b0;
        ibus_data_in = '0;
        dbus_ack     = 1'b0;
        dbus_data_in = '0;
        grant        = 2'b00;
        case (r_state)
            ST_GRANT_I: begin
                grant        = 2'b01;
                mem_cyc      = ibus_cyc & ~w_fire;
                mem_stb      = ibus_stb & ~w_fire;
                mem_we       = ibus_we;
                mem_wstrb    = ibus_wstrb;
                mem_addr     = ibus_addr;
                mem_data_out = ibus_data_out;
                ibus_ack     = (mem_ack & ibus_cyc & ~rst_core) | w_fire;
                ibus_data_in = w_fire ? w_dead : mem_data_in;
            end
            ST_GRANT_D: begin
                grant        = 2'b10;
                mem_cyc      = dbus_cyc & ~w_fire;
                mem_stb      = dbus_stb & ~w_fire;
                mem_we       = dbus_we;
                mem_wstrb    = dbus_wstrb;
                mem_addr     = dbus_addr;
                mem_data_out = dbus_data_out;
                dbus_ack     = (mem_ack & dbus_cyc & ~rst_core) | w_fire;
                dbus_data_in = w_fire ? w_dead : mem_data_in;
            end
            default: begin
                grant = 2'b00;
            end
        endcase
    end

    assign timeout = w_fire;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter: directed bench for wb_bus_arbiter. Masters push the read
// data they expect into per-master queues; a monitor pops and checks on every
// ack. Cycle-exact grant/routing checks run alongside the masters.
module tb_wb_bus_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk_core = 1'b0;
    logic          rst_core = 1'b1;
    logic          ibus_cyc, ibus_stb, ibus_we;
    logic [SW-1:0] ibus_wstrb;
    logic [AW-1:0] ibus_addr;
    logic [DW-1:0] ibus_data_out, ibus_data_in;
    logic          ibus_ack;
    logic          dbus_cyc, dbus_stb, dbus_we;
    logic [SW-1:0] dbus_wstrb;
    logic [AW-1:0] dbus_addr;
    logic [DW-1:0] dbus_data_out, dbus_data_in;
    logic          dbus_ack;
    logic          mem_cyc, mem_stb, mem_we;
    logic [SW-1:0] mem_wstrb;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_out, mem_data_in;
    logic          mem_ack;
    logic [1:0]    grant;
    logic          timeout;

    wb_bus_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_core(clk_core), .rst_core(rst_core),
        .ibus_cyc(ibus_cyc), .ibus_stb(ibus_stb), .ibus_we(ibus_we),
        .ibus_wstrb(ibus_wstrb), .ibus_addr(ibus_addr), .ibus_data_out(ibus_data_out),
        .ibus_data_in(ibus_data_in), .ibus_ack(ibus_ack),
        .dbus_cyc(dbus_cyc), .dbus_stb(dbus_stb), .dbus_we(dbus_we),
        .dbus_wstrb(dbus_wstrb), .dbus_addr(dbus_addr), .dbus_data_out(dbus_data_out),
        .dbus_data_in(dbus_data_in), .dbus_ack(dbus_ack),
        .mem_cyc(mem_cyc), .mem_stb(mem_stb), .mem_we(mem_we),
        .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_data_out(mem_data_out),
        .mem_data_in(mem_data_in), .mem_ack(mem_ack),
        .grant(grant), .timeout(timeout)
    );

    always #5 clk_core = ~clk_core;

    typedef struct {
        logic [31:0] data;
        logic        to;
    } exp_t;

    int   total = 0;
    int   bad   = 0;
    exp_t qi[$];
    exp_t qd[$];
    int   slave_wait  = 0;
    bit   slave_stall = 1'b0;
    bit   slave_force = 1'b0;
    int   wcnt        = 0;

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'h1234_5678;
        return {a[15:0], 16'hBEEF};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit m, input bit cyc, input bit stb, input bit we,
                         input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        if (m) begin
            dbus_cyc = cyc; dbus_stb = stb; dbus_we = we;
            dbus_addr = a; dbus_data_out = wd; dbus_wstrb = ws;
        end else begin
            ibus_cyc = cyc; ibus_stb = stb; ibus_we = we;
            ibus_addr = a; ibus_data_out = wd; ibus_wstrb = ws;
        end
    endtask

    // One master transaction of 'beats' back-to-back strobes inside one cyc.
    task automatic mtxn(input bit m, input logic [31:0] a, input bit we, input logic [31:0] wd,
                        input logic [3:0] ws, input int beats, input logic [31:0] exp_rd);
        int   n;
        exp_t e;
        e.data = exp_rd;
        e.to   = 1'b0;
        @(posedge clk_core); #2;
        drive(m, 1'b1, 1'b1, we, a, wd, ws);
        for (int b = 0; b < beats; b++) begin
            if (m) qd.push_back(e); else qi.push_back(e);
            n = 0;
            do begin
                @(negedge clk_core);
                n++;
            end while (((m ? dbus_ack : ibus_ack) !== 1'b1) && (n < 300));
            chk(m ? "dbus_ack_wait" : "ibus_ack_wait", 32'(m ? dbus_ack : ibus_ack), 32'd1);
            @(posedge clk_core); #2;
        end
        drive(m, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        @(posedge clk_core); #2;
        rst_core = 1'b1;
        @(posedge clk_core); #2;
        rst_core = 1'b0;
    endtask

    // Slave: acks after slave_wait stalled cycles; can stall forever or force ack.
    initial begin
        mem_ack = 1'b0;
        mem_data_in = '0;
        forever begin
            @(posedge clk_core); #3;
            if (slave_force) begin
                mem_ack = 1'b1;
                mem_data_in = 32'hFFFF_FFFF;
            end else if (mem_cyc && mem_stb && !slave_stall) begin
                if (wcnt >= slave_wait) begin
                    mem_ack = 1'b1;
                    mem_data_in = slave_rd(mem_addr);
                    wcnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_ack = 1'b0;
                mem_data_in = '0;
                if (!(mem_cyc && mem_stb)) wcnt = 0;
            end
        end
    end

    // Monitor: every ack pops the owning master's expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_core);
            if (ibus_ack === 1'b1) begin
                if (qi.size() == 0) begin
                    chk("ibus_ack_unexpected", 32'(ibus_ack), 32'd0);
                end else begin
                    e = qi.pop_front();
                    $display("ack ibus data=%h timeout=%0b", ibus_data_in, timeout);
                    chk("ibus_data_in", ibus_data_in, e.data);
                    chk("ibus_timeout", 32'(timeout), 32'(e.to));
                end
            end
            if (dbus_ack === 1'b1) begin
                if (qd.size() == 0) begin
                    chk("dbus_ack_unexpected", 32'(dbus_ack), 32'd0);
                end else begin
                    e = qd.pop_front();
                    $display("ack dbus data=%h timeout=%0b", dbus_data_in, timeout);
                    chk("dbus_data_in", dbus_data_in, e.data);
                    chk("dbus_timeout", 32'(timeout), 32'(e.to));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish actual=timeout required=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        int   nbad;
        exp_t e;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        rst_core = 1'b1;

        // Reset state
        @(posedge clk_core); @(negedge clk_core);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_mem_cyc", 32'(mem_cyc), 32'd0);
        chk("rst_mem_stb", 32'(mem_stb), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_data_out", mem_data_out, 32'd0);
        chk("rst_acks", 32'({ibus_ack, dbus_ack}), 32'd0);
        chk("rst_data_in", ibus_data_in | dbus_data_in, 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        @(posedge clk_core); #2;
        rst_core = 1'b0;

        // ibus read, 2 wait states
        slave_wait = 2;
        fork
            mtxn(1'b0, 32'h0000_0010, 1'b0, 32'h0, 4'h0, 1, 32'h1234_5678);
            begin
                @(posedge clk_core); @(negedge clk_core);
                chk("t1_stb_idle", 32'(mem_stb), 32'd0);
                @(negedge clk_core);
                chk("t1_stb_rise", 32'(mem_stb), 32'd1);
                chk("t1_grant", 32'(grant), 32'd1);
                chk("t1_mem_addr", mem_addr, 32'h0000_0010);
                for (int k = 0; k < 3; k++) begin
                    if (k > 0) @(negedge clk_core);
                    chk("t1_ibus_ack", 32'(ibus_ack), 32'(k == 2));
                    chk("t1_dbus_ack", 32'(dbus_ack), 32'd0);
                end
            end
        join

        // Tie out of reset: ibus first, then handoff to dbus without idle
        do_reset();
        slave_wait = 1;
        fork
            mtxn(1'b0, 32'h0000_0020, 1'b0, 32'h0, 4'h0, 1, 32'h0020_BEEF);
            mtxn(1'b1, 32'h0000_0024, 1'b0, 32'h0, 4'h0, 1, 32'h0024_BEEF);
            begin
                @(posedge clk_core); @(negedge clk_core);
                chk("t2_grant_idle", 32'(grant), 32'd0);
                @(negedge clk_core);
                chk("t2_grant_i", 32'(grant), 32'd1);
                @(negedge clk_core);
                chk("t2_ibus_ack", 32'(ibus_ack), 32'd1);
                @(negedge clk_core);
                chk("t2_release_grant", 32'(grant), 32'd1);
                chk("t2_release_cyc", 32'(mem_cyc), 32'd0);
                chk("t2_release_dack", 32'(dbus_ack), 32'd0);
                @(negedge clk_core);
                chk("t2_handoff_grant", 32'(grant), 32'd2);
                chk("t2_handoff_cyc", 32'(mem_cyc), 32'd1);
                chk("t2_handoff_addr", mem_addr, 32'h0000_0024);
            end
        join
        // Next tie goes back to ibus
        fork
            mtxn(1'b0, 32'h0000_0028, 1'b0, 32'h0, 4'h0, 1, 32'h0028_BEEF);
            mtxn(1'b1, 32'h0000_002C, 1'b0, 32'h0, 4'h0, 1, 32'h002C_BEEF);
            begin
                @(posedge clk_core); @(negedge clk_core);
                chk("t2b_grant_idle", 32'(grant), 32'd0);
                @(negedge clk_core);
                chk("t2b_grant_i", 32'(grant), 32'd1);
            end
        join

        // dbus write with ibus held off
        slave_wait = 3;
        fork
            mtxn(1'b1, 32'h0000_0100, 1'b1, 32'hA5A5_A5A5, 4'b0011, 1, 32'h0100_BEEF);
            begin
                @(posedge clk_core);
                mtxn(1'b0, 32'h0000_0030, 1'b0, 32'h0, 4'h0, 1, 32'h0030_BEEF);
            end
            begin
                @(posedge clk_core); @(negedge clk_core);
                @(negedge clk_core);
                chk("t3_mem_we", 32'(mem_we), 32'd1);
                chk("t3_mem_wstrb", 32'(mem_wstrb), 32'h3);
                chk("t3_mem_data_out", mem_data_out, 32'hA5A5_A5A5);
                chk("t3_mem_addr", mem_addr, 32'h0000_0100);
                for (int k = 0; k < 4; k++) begin
                    if (k > 0) @(negedge clk_core);
                    chk("t3_grant_d", 32'(grant), 32'd2);
                    chk("t3_ibus_held", 32'(ibus_ack), 32'd0);
                end
                @(negedge clk_core);
                chk("t3_release_grant", 32'(grant), 32'd2);
                @(negedge clk_core);
                chk("t3_ibus_grant", 32'(grant), 32'd1);
            end
        join

        // dbus three back-to-back beats in one cyc
        slave_wait = 0;
        fork
            mtxn(1'b1, 32'h0000_0200, 1'b0, 32'h0, 4'h0, 3, 32'h0200_BEEF);
            begin
                @(posedge clk_core);
                mtxn(1'b0, 32'h0000_0040, 1'b0, 32'h0, 4'h0, 1, 32'h0040_BEEF);
            end
            begin
                @(posedge clk_core); @(negedge clk_core);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk_core);
                    chk("t4_grant_d", 32'(grant), 32'd2);
                    chk("t4_dbus_ack", 32'(dbus_ack), 32'(k < 3));
                    chk("t4_ibus_held", 32'(ibus_ack), 32'd0);
                end
                @(negedge clk_core);
                chk("t4_ibus_grant", 32'(grant), 32'd1);
            end
        join

        // Reset mid-transfer with a stalled slave (ibus owns, so last_grant = ibus)
        slave_stall = 1'b1;
        @(posedge clk_core); #2;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0050, 32'h0, 4'h0);
        @(negedge clk_core);
        @(negedge clk_core);
        chk("t5_grant_i", 32'(grant), 32'd1);
        chk("t5_mem_cyc", 32'(mem_cyc), 32'd1);
        @(posedge clk_core); #2;
        rst_core = 1'b1;
        slave_force = 1'b1;
        @(negedge clk_core);
        chk("t5_rst_acks", 32'({ibus_ack, dbus_ack}), 32'd0);
        @(posedge clk_core); #2;
        rst_core = 1'b0;
        slave_force = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk_core);
        chk("t5_post_mem_cyc", 32'(mem_cyc), 32'd0);
        chk("t5_post_grant", 32'(grant), 32'd0);
        chk("t5_post_acks", 32'({ibus_ack, dbus_ack}), 32'd0);
        slave_stall = 1'b0;
        slave_wait = 1;
        fork
            mtxn(1'b0, 32'h0000_0060, 1'b0, 32'h0, 4'h0, 1, 32'h0060_BEEF);
            mtxn(1'b1, 32'h0000_0064, 1'b0, 32'h0, 4'h0, 1, 32'h0064_BEEF);
            begin
                @(posedge clk_core); @(negedge clk_core);
                chk("t5_tie_idle", 32'(grant), 32'd0);
                @(negedge clk_core);
                chk("t5_tie_grant_i", 32'(grant), 32'd1);
            end
        join

        // Stalled slave: watchdog or indefinite hold
        slave_stall = 1'b1;
        @(posedge clk_core); #2;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0070, 32'h0, 4'h0);
        @(negedge clk_core);
`ifdef WB_ARB_TIMEOUT_EN
        e.data = 32'hDEAD_BEEF;
        e.to   = 1'b1;
        qi.push_back(e);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_core);
            chk("t6_timeout", 32'(timeout), 32'(k == 3));
            chk("t6_ibus_ack", 32'(ibus_ack), 32'(k == 3));
            chk("t6_mem_stb", 32'(mem_stb), 32'(k != 3));
        end
        @(posedge clk_core); #2;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk_core);
        chk("t6_idle_grant", 32'(grant), 32'd0);
        chk("t6_idle_timeout", 32'(timeout), 32'd0);
`else
        nbad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk_core);
            if (grant !== 2'b01 || timeout !== 1'b0 || ibus_ack !== 1'b0) nbad++;
        end
        chk("t6_hold_bad_cycles", 32'(nbad), 32'd0);
        @(posedge clk_core); #2;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk_core);
        @(negedge clk_core);
        chk("t6_idle_grant", 32'(grant), 32'd0);
`endif
        slave_stall = 1'b0;

        @(posedge clk_core);
        chk("qi_drained", 32'(qi.size()), 32'd0);
        chk("qd_drained", 32'(qd.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_bus_arbiter.md
# wb_bus_arbiter

Two-master, one-slave Wishbone arbiter that shares the single core memory port between the core's instruction bus and data bus. It is used in builds where ENABLE_SECOND_MEMORY is not defined: its slave side connects to the Controller's core_* bus, and its two master sides connect to the core's fetch and load/store interfaces. It uses round-robin arbitration with a registered grant, and holds the grant for the full duration of a master's cyc. An optional watchdog terminates stalled transfers.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of all three ports
- DATA_WIDTH, 32, data width; strobe width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 255, maximum stalled cycles before the watchdog fires; used only with WB_ARB_TIMEOUT_EN; must be ≥ 1

Ports:
- clk_core  in  1  core clock; the only clock
- rst_core  in  1  reset, synchronous, active-high
- ibus_cyc, ibus_stb, ibus_we  in  1 each  instruction master request
- ibus_wstrb  in  DATA_WIDTH/8  instruction master byte strobes
- ibus_addr  in  ADDR_WIDTH  instruction master address
- ibus_data_out  in  DATA_WIDTH  instruction master write data
- ibus_data_in  out  DATA_WIDTH  read data to the instruction master
- ibus_ack  out  1  acknowledge to the instruction master
- dbus_*  same set of signals, widths and directions as ibus_*  data master
- mem_cyc, mem_stb, mem_we  out  1 each  slave request (to core_cyc/core_stb/core_we)
- mem_wstrb  out  DATA_WIDTH/8  slave byte strobes
- mem_addr  out  ADDR_WIDTH  slave address
- mem_data_out  out  DATA_WIDTH  slave write data
- mem_data_in  in  DATA_WIDTH  slave read data
- mem_ack  in  1  slave acknowledge
- grant  out  2  one-hot current grant: bit0 = ibus, bit1 = dbus; 2'b00 in IDLE
- timeout  out  1  one-cycle pulse when the watchdog terminates a transfer

## Operation
- A master is requesting when its cyc and stb are both high.
- State machine has three states: IDLE, GRANT_I, GRANT_D. The state is registered. last_grant is a 1-bit register.
- IDLE transitions:
  - Only one master requesting → GRANT of that master.
  - Both requesting → grant the master that was not served last (last_grant).
  - No master requesting → stay in IDLE.
- Whenever a GRANT state is entered, last_grant is updated to the granted master.
- GRANT_x behaviour:
  - Master x's cyc, stb, we, wstrb, addr and data_out are routed combinationally to mem_*.
  - mem_ack is routed to x_ack, and mem_data_in to x_data_in.
  - The non-granted master sees ack = 0 and data_in = 0.
- GRANT_x exit:
  - Stay while x_cyc is high. Multi-beat and back-to-back stb within one cyc keep the grant.
  - When x_cyc is low and the other master is requesting → go directly to GRANT_other (handoff with no idle cycle).
  - When x_cyc is low and no other master is requesting → IDLE.
- In IDLE, every mem_* output and both acks are 0.
- While mem_cyc is low, a mem_ack is ignored and is not forwarded.
- Reset values: state = IDLE, last_grant = dbus (so ibus wins the first tie), grant = 0, timeout = 0, all mem_* = 0, both acks = 0, both data_in = 0.

## Timing
- Arbitration latency: a request first visible at edge N (state IDLE) appears on mem_* after edge N+1, i.e. one cycle.
- With the grant already held, the request-to-slave path and the ack/data return path are both zero-latency (combinational).
- Handoff: the first cycle with x_cyc low and the other master requesting is followed by the other master's request on mem_* in the next cycle.
- Reset mid-transfer: state becomes IDLE at the reset edge. mem_cyc is 0 in the following cycle. No ack is forwarded during reset.
- Simultaneous requests with ties alternate strictly: I, D, I, D, …

## Configuration
- WB_ARB_TIMEOUT_EN defined:
  - An 8..32-bit counter (sized from TIMEOUT_CYCLES) clears on entering a GRANT state and on each mem_ack.
  - It increments on each GRANT cycle with mem_stb high and mem_ack low.
  - When the count equals TIMEOUT_CYCLES, for one cycle: mem_cyc/mem_stb are forced to 0, x_ack is 1, x_data_in is 32'hDEAD_BEEF (zero-extended or truncated to DATA_WIDTH), and timeout is 1.
  - The next state is then IDLE, and last_grant is unchanged.
- WB_ARB_TIMEOUT_EN not defined: no counter is built, timeout is tied to 0, and a stalled slave holds the grant indefinitely.

## Test plan
- Reset, then ibus read of addr 0x0000_0010, slave acks after 2 cycles with 0x1234_5678 → mem_stb rises 1 cycle after the request; ibus_ack is high in the same cycle as mem_ack; ibus_data_in = 0x1234_5678; dbus_ack stays 0; grant = 2'b01.
- Both masters request in the same cycle out of reset → ibus served first. ibus drops cyc after its ack → the next cycle grant = 2'b10 with no IDLE cycle. Next tie → ibus served again.
- dbus write, addr 0x0000_0100, data 0xA5A5_A5A5, wstrb 4'b0011 → mem_we = 1, mem_wstrb = 4'b0011, mem_data_out = 0xA5A5_A5A5. A concurrent ibus request is held off (ibus_ack = 0) until dbus_cyc falls.
- dbus holds cyc across 3 back-to-back stb beats → grant stays 2'b10 throughout; ibus (requesting) is granted only after dbus_cyc falls.
- rst_core asserted for 1 cycle mid-transfer while the slave is stalled → the next cycle has mem_cyc = 0, grant = 0, and no ack to either master. After release, the first tie goes to ibus.
- With WB_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 4, the slave never acks an ibus read → on the 4th stalled cycle, ibus_ack = 1, ibus_data_in = 0xDEAD_BEEF, timeout = 1 for one cycle, state returns to IDLE. Without the macro, the grant is held for 100 cycles and timeout stays 0.
